ph_fifo_bank: RTL
=================

# ph_fifo_bank

Parametrised parasite-to-host data register bank for the Tube: NUM_CH independent channels, each a DEPTH-entry FIFO of DATA_W bits. One channel (MODE_CH) supports the one-byte/multi-byte mode switch with a fill-then-drain availability state machine and a zero-bytes flag for the host interrupt logic. It sits between the parasite bus write decode and the host read mux, in a single clock domain.

## Interface
- NUM_CH, 4: channel count, 1..8
- DEPTH, 2: entries per channel, power of two, 2..64
- DATA_W, 8: data width
- MODE_CH, 2: index of the channel with mode switching
- MULTI_THRESH, 2: fill level, 1..DEPTH, that arms availability on MODE_CH in multi-byte mode

Ports:
- h_phi2  in  1  clock; all state changes on rising edge
- h_rst  in  1  synchronous reset, active-high
- p_data  in  DATA_W  parasite write data
- p_selectData  in  NUM_CH  parasite channel select, one-hot
- p_wr  in  1  parasite write strobe, one cycle per write
- h_selectData  in  NUM_CH  host channel select; lowest set bit wins
- h_rd  in  1  host read strobe, one cycle per read
- one_byte_mode  in  1  MODE_CH mode: 1 = one-byte, 0 = multi-byte
- h_data  out  DATA_W  head entry of selected channel
- h_data_available  out  NUM_CH  per-channel host data-available flag
- h_zero_bytes_available  out  1  MODE_CH occupancy is zero
- p_full  out  NUM_CH  per-channel full flag to parasite
- h_overflow  out  NUM_CH  sticky dropped-write flags; present only with PH_FIFO_BANK_OVF_EN

## Operation
- Per channel: write pointer, read pointer (modulo DEPTH), count of width clog2(DEPTH)+1.
- Push: p_wr & p_selectData[i] & !p_full[i]. Push while full is dropped; state unchanged.
- Pop: h_rd & sel[i] & count!=0, where sel is h_selectData reduced to its lowest set bit. Pop while empty is ignored.
- Push and pop on one channel in the same cycle both take effect; count unchanged. The only exception is an empty channel, where the push is accepted and the pop ignored.
- Full for a normal channel is count==DEPTH. For MODE_CH in one-byte mode, full is count>=1.
- h_data: head entry of the selected channel. It is forced to 0 when no bit is selected or the selected channel is empty.
- h_data_available[i] for a normal channel is count!=0.
- MODE_CH availability FSM:
  - IDLE: available=0. Go to FILL on the first push.
  - FILL: available=0. Go to DRAIN when count reaches MULTI_THRESH.
  - DRAIN: available=1. Go to IDLE when count reaches 0.
- In one-byte mode MODE_CH ignores the FSM and uses available = count!=0. The FSM is held in IDLE if empty and in DRAIN otherwise.
- Mode change mid-operation takes effect the next cycle. No data is discarded. If count>1 on switching to one-byte mode, p_full stays asserted until the channel drains to 0.
- h_zero_bytes_available = (MODE_CH count==0).

## Timing
- Reset state: all counts and pointers 0; FSM IDLE; p_full=0; h_data_available=0; h_zero_bytes_available=1; h_overflow=0; h_data=0. Storage array is not reset.
- p_full, h_data_available and h_zero_bytes_available are decoded combinationally from registered state. They update in the cycle after the causing push or pop.
- Write-to-read latency is 1 cycle: data pushed at edge N is on h_data, with available set, after edge N.
- After a pop at edge N, the next entry is on h_data after edge N.
- h_rst asserted mid-operation discards all contents at that edge. A strobe in the reset cycle is ignored.

## Configuration
- PH_FIFO_BANK_OVF_EN defined:
  - h_overflow[i] sets on a dropped push to channel i.
  - The flag clears only on reset or on a host read of channel i that pops.
  - If set and clear coincide, set wins.
- Undefined: the h_overflow port and its logic are absent; dropped pushes are silent.

## Structure
- Package ph_fifo_pkg holds:
  - the MODE_CH FSM state enum (IDLE, FILL, DRAIN)
  - the count-width function clog2(DEPTH)+1
  - the parameter range checks
- Sub-module ph_fifo_chan holds one channel (storage, pointers, count, full/empty, optional overflow) and is generated NUM_CH times.
- The bank holds select reduction, output mux, the MODE_CH FSM and the mode-dependent full override.

## Test plan
- Reset, then push 0xA5 to ch0 → next cycle h_data_available=0001 and h_data=0xA5 with h_selectData=0001. Pop → available=0000 and h_data=0x00.
- DEPTH=4: push 0x11..0x55 to ch1 → p_full[1]=1 after the 4th push, the 5th is dropped, pops return 0x11..0x44, h_overflow[1]=1 until the first pop.
- MODE_CH=2, multi-byte, MULTI_THRESH=2:
  - Push 0x01 → available[2]=0 and h_zero_bytes_available=0.
  - Push 0x02 → available[2]=1.
  - Pop once → available[2] stays 1.
  - Pop again → available[2]=0 and h_zero_bytes_available=1.
- one_byte_mode=1: push 0x7E to ch2 → p_full[2]=1. A second push is dropped. Pop → 0x7E and p_full[2]=0.
- Push and pop on a 1-entry ch3 in the same cycle → count stays 1, head advances. The same on an empty channel → count becomes 1.
- Assert h_rst with 3 entries in ch0 → all flags return to reset values next cycle; h_data=0 with any select.

Source files
------------

// File: rtl/ph_fifo_pkg.sv
// ph_fifo_pkg: shared types, count width and parameter checks for ph_fifo_bank
package ph_fifo_pkg;
  typedef enum logic [1:0] {IDLE, FILL, DRAIN} mode_state_t;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic bit params_ok(input int num_ch, input int depth, input int data_w, input int mode_ch, input int thresh);
    return num_ch >= 1 && num_ch <= 8 && depth >= 2 && depth <= 64 && (depth & (depth - 1)) == 0 &&
           data_w >= 1 && mode_ch >= 0 && mode_ch < num_ch && thresh >= 1 && thresh <= depth;
  endfunction
endpackage

// File: rtl/ph_fifo_chan.sv
// ph_fifo_chan: one FIFO channel with storage, pointers, count, full decode and sticky overflow under PH_FIFO_BANK_OVF_EN
module ph_fifo_chan
  import ph_fifo_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr,
  input  logic                      rd,
  input  logic [DATA_W-1:0]         din,
  input  logic                      force_full,
  output logic                      full,
  output logic [cnt_w(DEPTH)-1:0]   cnt,
  output logic [DATA_W-1:0]         head
`ifdef PH_FIFO_BANK_OVF_EN
  ,
  output logic                      ovf
`endif
);
  localparam int CW = cnt_w(DEPTH);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic push_ok, pop_ok;
  assign full    = cnt == CW'(DEPTH) || force_full;
  assign push_ok = wr && !full;
  assign pop_ok  = rd && cnt != '0;
  assign head    = mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      wp  <= push_ok ? wp + 1'b1 : wp;
      rp  <= pop_ok ? rp + 1'b1 : rp;
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem[wp] <= din;
  end
`ifdef PH_FIFO_BANK_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) ovf <= 1'b0;
    else if (wr && full) ovf <= 1'b1;
    else if (pop_ok) ovf <= 1'b0;
  end
`endif
endmodule

// File: rtl/ph_fifo_bank.sv
// ph_fifo_bank: parasite-to-host FIFO bank with mode-switched channel MODE_CH; h_overflow present with PH_FIFO_BANK_OVF_EN
module ph_fifo_bank
  import ph_fifo_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DEPTH        = 2,
  parameter int DATA_W       = 8,
  parameter int MODE_CH      = 2,
  parameter int MULTI_THRESH = 2
) (
  input  logic              h_phi2,
  input  logic              h_rst,
  input  logic [DATA_W-1:0] p_data,
  input  logic [NUM_CH-1:0] p_selectData,
  input  logic              p_wr,
  input  logic [NUM_CH-1:0] h_selectData,
  input  logic              h_rd,
  input  logic              one_byte_mode,
  output logic [DATA_W-1:0] h_data,
  output logic [NUM_CH-1:0] h_data_available,
  output logic              h_zero_bytes_available,
  output logic [NUM_CH-1:0] p_full
`ifdef PH_FIFO_BANK_OVF_EN
  ,
  output logic [NUM_CH-1:0] h_overflow
`endif
);
  localparam int CW = cnt_w(DEPTH);
  if (!params_ok(NUM_CH, DEPTH, DATA_W, MODE_CH, MULTI_THRESH)) begin : g_bad_params
    $error("ph_fifo_bank: parameter out of range");
  end
  logic [NUM_CH-1:0] sel;
  logic [CW-1:0] cnt [NUM_CH];
  logic [DATA_W-1:0] head [NUM_CH];
  logic mode_q, mc_push, mc_pop;
  logic [CW-1:0] nc;
  mode_state_t st, st_nxt;
  assign sel     = h_selectData & (~h_selectData + 1'b1);
  assign mc_push = p_wr && p_selectData[MODE_CH] && !p_full[MODE_CH];
  assign mc_pop  = h_rd && sel[MODE_CH] && cnt[MODE_CH] != '0;
  assign nc      = cnt[MODE_CH] + CW'(mc_push) - CW'(mc_pop);
  assign h_zero_bytes_available = cnt[MODE_CH] == '0;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ph_fifo_chan #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_chan (
      .clk        (h_phi2),
      .rst        (h_rst),
      .wr         (p_wr && p_selectData[i]),
      .rd         (h_rd && sel[i]),
      .din        (p_data),
      .force_full (i == MODE_CH && mode_q && cnt[i] != '0),
      .full       (p_full[i]),
      .cnt        (cnt[i]),
      .head       (head[i])
`ifdef PH_FIFO_BANK_OVF_EN
      ,
      .ovf        (h_overflow[i])
`endif
    );
    assign h_data_available[i] = (i == MODE_CH && !mode_q) ? st == DRAIN : cnt[i] != '0;
  end
  always_comb begin
    h_data = '0;
    for (int k = 0; k < NUM_CH; k++) h_data = (sel[k] && cnt[k] != '0) ? head[k] : h_data;
  end
  always_comb begin
    st_nxt = st;
    if (mode_q) st_nxt = nc == '0 ? IDLE : DRAIN;
    else if (st == IDLE) st_nxt = mc_push ? (nc >= CW'(MULTI_THRESH) ? DRAIN : FILL) : IDLE;
    else st_nxt = nc == '0 ? IDLE : (nc >= CW'(MULTI_THRESH) || st == DRAIN) ? DRAIN : FILL;
  end
  always_ff @(posedge h_phi2) begin
    if (h_rst) begin
      st     <= IDLE;
      mode_q <= 1'b0;
    end else begin
      st     <= st_nxt;
      mode_q <= one_byte_mode;
    end
  end
endmodule
